// File: rtl/seg_display_scan_if.sv
// rtl/seg_display_scan_if.sv - source selection inputs and 7-segment drive outputs
interface seg_display_scan_if;
    logic [1:0]  sel;
    logic        blank_lz;
    logic [31:0] display_in;
    logic [31:0] cycle_in;
    logic [31:0] pred_ok_in;
    logic [31:0] pred_fail_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport slave (
        input  sel, blank_lz, display_in, cycle_in, pred_ok_in, pred_fail_in,
        output an, seg, dp
    );

    modport master (
        output sel, blank_lz, display_in, cycle_in, pred_ok_in, pred_fail_in,
        input  an, seg, dp
    );
endinterface

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - 8-digit hex scanner for a common-anode 7-segment display
module seg_display_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 8
) (
    input  logic                clk,
    input  logic                clr,
    seg_display_scan_if.slave   io
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [31:0]   snap;
    logic [1:0]    sel_q;
    logic          reload;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [31:0]   src;
    logic [31:0]   shifted;
    logic          tick;
    logic          last;
    logic          blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        src = io.display_in;
        case (io.sel)
            2'd0: src = io.display_in;
            2'd1: src = io.cycle_in;
            2'd2: src = io.pred_ok_in;
            default: src = io.pred_fail_in;
        endcase
    end

    // Shifting the current digit down to bit 0 also exposes everything above it for blanking.
    assign shifted = snap >> {idx, 2'b00};
    assign tick    = (div_cnt == DW'(SCAN_DIV - 1));
    assign last    = (idx == 3'(DIGITS - 1));
    assign blank   = io.blank_lz && (idx != 3'd0) && (shifted == 32'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
            idx     <= 3'd0;
            snap    <= 32'd0;
            sel_q   <= io.sel;
            reload  <= 1'b1;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            sel_q  <= io.sel;
            reload <= (io.sel != sel_q);
            an_q   <= ~(8'h01 << idx);
            seg_q  <= blank ? 7'h7F : hex7(shifted[3:0]);
            dp_q   <= ({1'b0, io.sel} != idx);
            // A pending reload restarts the frame and suppresses any coincident tick.
            if (reload) begin
                snap    <= src;
                idx     <= 3'd0;
                div_cnt <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                idx     <= last ? 3'd0 : idx + 3'd1;
                if (last) begin
                    snap <= src;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    assign io.an  = an_q;
    assign io.seg = seg_q;
    assign io.dp  = dp_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - vector table, corner sequences and random run against a timing model
module tb_seg_display_scan;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    seg_display_scan_if bus();

    seg_display_scan #(.SCAN_DIV(SD), .DIGITS(8)) dut (
        .clk (clk),
        .clr (clr),
        .io  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [1:0]  sel;
        logic        blank;
        logic [31:0] val;
        int          digit;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;
    vec_t tab[$];

    // Reference model: digit position and frame loads derived from edges elapsed since the last restart.
    int          k = 0;
    int          m_start = 0;
    int          m_digit = 0;
    logic [31:0] m_snap = 32'd0;
    bit          m_reload = 1'b1;
    logic [1:0]  m_selq = 2'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] src_of(input logic [1:0] s);
        case (s)
            2'd0: return bus.display_in;
            2'd1: return bus.cycle_in;
            2'd2: return bus.pred_ok_in;
            default: return bus.pred_fail_in;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [31:0] sh;
        int          el;
        if (clr) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            m_snap = 32'd0; m_digit = 0; m_reload = 1'b1; m_selq = bus.sel;
        end else begin
            sh    = m_snap >> (4 * m_digit);
            e_an  = ~(8'h01 << m_digit);
            e_seg = (bus.blank_lz && m_digit != 0 && sh == 32'd0) ? 7'h7F : hex_tab[sh[3:0]];
            e_dp  = (m_digit == int'(bus.sel)) ? 1'b0 : 1'b1;
            if (m_reload) begin
                m_snap = src_of(bus.sel); m_start = k; m_digit = 0;
            end else begin
                el = k - m_start;
                m_digit = (el / SD) % 8;
                if (el % (8 * SD) == 0) m_snap = src_of(bus.sel);
            end
            m_reload = (bus.sel != m_selq);
            m_selq = bus.sel;
        end
        k++;
        chk("model", {16'd0, bus.an, bus.seg, bus.dp}, {16'd0, e_an, e_seg, e_dp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wait_an(input logic [7:0] tgt, input int bound, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            step();
            if (bus.an === tgt) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s an timeout act=%h exp=%h", nm, bus.an, tgt);
        end
    endtask

    task automatic set_src(input logic [1:0] s, input logic [31:0] v);
        bus.display_in = 32'd0; bus.cycle_in = 32'd0;
        bus.pred_ok_in = 32'd0; bus.pred_fail_in = 32'd0;
        case (s)
            2'd0: bus.display_in = v;
            2'd1: bus.cycle_in = v;
            2'd2: bus.pred_ok_in = v;
            default: bus.pred_fail_in = v;
        endcase
        bus.sel = s;
    endtask

    task automatic restart();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step(); step(); step();
    endtask

    task automatic add(input logic [1:0] s, input logic b, input logic [31:0] v,
                       input int d, input logic [6:0] sg, input logic p);
        vec_t x;
        x.sel = s; x.blank = b; x.val = v; x.digit = d; x.seg = sg; x.dp = p;
        tab.push_back(x);
    endtask

    initial begin
        int fe_cnt;
        logic [6:0] mid_seg [5];
        mid_seg = '{7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

        clr = 1'b1;
        bus.blank_lz = 1'b0;
        set_src(2'd0, 32'h76543210);

        // Reset holds the display dark, then digit 0 lights shortly after release.
        step();
        step();
        chk("reset_an", {24'd0, bus.an}, 32'hFF);
        chk("reset_seg", {25'd0, bus.seg}, 32'h7F);
        chk("reset_dp", {31'd0, bus.dp}, 32'd1);
        clr = 1'b0;
        step();
        step();
        chk("release_an", {24'd0, bus.an}, 32'hFE);
        chk("release_seg", {25'd0, bus.seg}, 32'h40);

        for (int d = 0; d < 8; d++) add(2'd0, 1'b0, 32'h76543210, d, hex_tab[d], d != 0);
        add(2'd0, 1'b1, 32'h000000A5, 0, 7'h12, 1'b0);
        add(2'd0, 1'b1, 32'h000000A5, 1, 7'h08, 1'b1);
        add(2'd0, 1'b1, 32'h000000A5, 2, 7'h7F, 1'b1);
        add(2'd0, 1'b1, 32'h000000A5, 7, 7'h7F, 1'b1);
        add(2'd0, 1'b1, 32'h00000000, 0, 7'h40, 1'b0);
        add(2'd0, 1'b1, 32'h00000000, 1, 7'h7F, 1'b1);
        add(2'd2, 1'b0, 32'h00000012, 0, 7'h24, 1'b1);
        add(2'd2, 1'b0, 32'h00000012, 2, 7'h40, 1'b0);
        add(2'd3, 1'b0, 32'h89ABCDEF, 0, 7'h0E, 1'b1);
        add(2'd3, 1'b0, 32'h89ABCDEF, 3, 7'h46, 1'b0);
        add(2'd3, 1'b0, 32'h89ABCDEF, 7, 7'h00, 1'b1);
        add(2'd1, 1'b1, 32'h0000BEEF, 1, 7'h06, 1'b0);
        add(2'd1, 1'b1, 32'h0000BEEF, 4, 7'h7F, 1'b1);

        foreach (tab[i]) begin
            bus.blank_lz = tab[i].blank;
            set_src(tab[i].sel, tab[i].val);
            restart();
            wait_an(~(8'h01 << tab[i].digit), 100, $sformatf("tab%0d_wait", i));
            chk($sformatf("tab%0d_seg", i), {25'd0, bus.seg}, {25'd0, tab[i].seg});
            chk($sformatf("tab%0d_dp", i), {31'd0, bus.dp}, {31'd0, tab[i].dp});
        end

        // Mid-frame source change is held off until the next frame.
        bus.blank_lz = 1'b0;
        set_src(2'd0, 32'h76543210);
        restart();
        wait_an(8'hF7, 100, "mid_wait3");
        bus.display_in = 32'hFFFFFFFF;
        for (int d = 3; d < 8; d++) begin
            wait_an(~(8'h01 << d), 40, $sformatf("mid_wait%0d", d));
            chk($sformatf("mid_seg%0d", d), {25'd0, bus.seg}, {25'd0, mid_seg[d-3]});
        end
        wait_an(8'hFE, 40, "mid_wrap");
        chk("mid_new_seg", {25'd0, bus.seg}, 32'h0E);

        // Source switch restarts the scan at digit 0.
        wait_an(8'hDF, 100, "sel_wait5");
        bus.pred_ok_in = 32'h12;
        bus.sel = 2'd2;
        wait_an(8'hFE, 4, "sel_restart");
        chk("sel_seg", {25'd0, bus.seg}, 32'h24);
        wait_an(8'hFB, 40, "sel_wait2");
        chk("sel_dp", {31'd0, bus.dp}, 32'd0);

        // Clear in the middle of digit 6 dwell, then digit 0 gets a full dwell plus the reload cycle.
        set_src(2'd0, 32'h76543210);
        restart();
        wait_an(8'hBF, 100, "clr_wait6");
        step();
        clr = 1'b1;
        step();
        chk("clr_an", {24'd0, bus.an}, 32'hFF);
        chk("clr_seg", {25'd0, bus.seg}, 32'h7F);
        clr = 1'b0;
        fe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.an == 8'hFE) fe_cnt++;
        end
        chk("clr_dwell", fe_cnt, SD + 1);

        // Random traffic: every cycle compared against the model.
        restart();
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) bus.sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.display_in   = $urandom() >> $urandom_range(0, 31);
                    1: bus.cycle_in     = $urandom() >> $urandom_range(0, 31);
                    2: bus.pred_ok_in   = $urandom() >> $urandom_range(0, 31);
                    default: bus.pred_fail_in = $urandom() >> $urandom_range(0, 31);
                endcase
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
